// File: rtl/data_mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_stage_pkg
// Shared definitions for the memory-access stage:
//   - wait-state FSM encoding (IDLE/WAIT/DONE)
//   - default number of wait states per load/store
//   - word-alignment constant and misalignment helper
// -----------------------------------------------------------------------------
package data_mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WAIT_CYCLES = 1;

  // Byte-offset bits of a word-aligned address.
  localparam logic [1:0] WORD_ALIGN = 2'b00;

  // A word access is misaligned when its byte offset is not zero.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return (byte_off != WORD_ALIGN);
  endfunction

endpackage

// File: rtl/data_mem_stage_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// 2^ADDR_W x 32-bit data RAM: synchronous write, asynchronous read, no reset.
// Ports:
//   i_clk    - rising-edge write clock
//   i_we     - write enable, sampled at the rising edge
//   i_addr   - word index (shared by read and write)
//   i_wdata  - write data
//   o_rdata  - combinational read data at i_addr
// -----------------------------------------------------------------------------
module dmem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_W)-1];

  // Write port: contents survive reset by design.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_stage.sv
// -----------------------------------------------------------------------------
// data_mem_stage
// Memory-access stage behind a single-cycle MIPS datapath. Owns the data RAM
// and a wait-state FSM that stalls the CPU for WAIT_CYCLES extra cycles per
// load/store, and flags misaligned word accesses (sticky).
//
// Ports:
//   Clock       in   rising-edge clock
//   Reset       in   asynchronous active-low reset
//   ALU_result  in   byte address for loads/stores, pass-through otherwise
//   WriteData   in   store data
//   MemWrite    in   store request (wins when MemtoReg is also set)
//   MemtoReg    in   load request / write-back select
//   DataToWd    out  register write-back data (combinational)
//   ReadData    out  data of the last completed load (registered)
//   Stall       out  CPU holds PC and register write while high
//   AddrErr     out  sticky misaligned-access flag
//   LoadCount   out  completed-load counter, saturating  (DMEM_PERF_CNT_EN only)
//   StoreCount  out  completed-store counter, saturating (DMEM_PERF_CNT_EN only)
//
// Optional feature macro: DMEM_PERF_CNT_EN adds LoadCount/StoreCount.
//
// Timing of one aligned access: IDLE (decode, stalled), WAIT_CYCLES x WAIT
// (stalled), DONE (not stalled, result valid); it retires at the DONE edge.
// -----------------------------------------------------------------------------
module data_mem_stage
  import data_mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int CNT_W       = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] ALU_result,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  output logic [31:0] DataToWd,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AddrErr
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] LoadCount,
  output logic [CNT_W-1:0] StoreCount
`endif
);

  // Wait counter only has to hold WAIT_CYCLES-1.
  localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LOAD =
    WCNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [31:0]        r_read_data;
  logic               r_addr_err;

  logic               w_req;
  logic               w_store;
  logic               w_load;
  logic               w_mis;
  logic               w_retire;
  logic               w_ram_we;
  logic [ADDR_W-1:0]  w_idx;
  logic [31:0]        w_ram_rdata;

  assign w_req   = MemWrite | MemtoReg;
  // Both request bits set is treated as a store.
  assign w_store = MemWrite;
  assign w_load  = MemtoReg & ~MemWrite;
  assign w_mis   = w_req & is_misaligned(ALU_result[1:0]);
  // Upper address bits are ignored: addresses alias modulo 2^(ADDR_W+2).
  assign w_idx   = ALU_result[ADDR_W+1:2];

  // DONE is the single cycle in which an access completes.
  assign w_retire = (r_state == ST_DONE);
  // State is forced to IDLE while Reset is low, so a pending store is dropped.
  assign w_ram_we = w_retire & w_store;

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (Clock),
    .i_we    (w_ram_we),
    .i_addr  (w_idx),
    .i_wdata (WriteData),
    .o_rdata (w_ram_rdata)
  );

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the combinational Stall / write-back outputs.
  always_comb begin
    w_state_nxt = r_state;
    Stall       = 1'b0;
    DataToWd    = ALU_result;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !w_mis) begin
          Stall = 1'b1;
          if (WAIT_CYCLES > 0) begin
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else if (w_mis && w_load) begin
          // Suppressed load returns zero instead of stale RAM data.
          DataToWd    = 32'h0000_0000;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        Stall = 1'b1;
        if (r_wcnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (w_load) begin
          DataToWd = w_ram_rdata;
        end else begin
          DataToWd = ALU_result;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // During reset the stage is transparent even if a request is presented.
    if (!Reset) begin
      Stall    = 1'b0;
      DataToWd = ALU_result;
    end else begin
      Stall    = Stall;
      DataToWd = DataToWd;
    end
  end

  // Wait-state counter: loaded on IDLE->WAIT, counts down to zero in WAIT.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_wcnt <= '0;
    end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_WAIT)) begin
      r_wcnt <= WCNT_LOAD;
    end else if ((r_state == ST_WAIT) && (r_wcnt != '0)) begin
      r_wcnt <= r_wcnt - WCNT_W'(1);
    end else begin
      r_wcnt <= r_wcnt;
    end
  end

  // Load data register, updated when a load leaves DONE.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_read_data <= 32'h0000_0000;
    end else if (w_retire && w_load) begin
      r_read_data <= w_ram_rdata;
    end else begin
      r_read_data <= r_read_data;
    end
  end

  // Sticky misalignment flag; only decoded in IDLE where requests start.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_addr_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_mis) begin
      r_addr_err <= 1'b1;
    end else begin
      r_addr_err <= r_addr_err;
    end
  end

  assign ReadData = r_read_data;
  assign AddrErr  = r_addr_err;

`ifdef DMEM_PERF_CNT_EN
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_store_cnt;

  // Saturating count of completed loads.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_load_cnt <= '0;
    end else if (w_retire && w_load && (r_load_cnt != '1)) begin
      r_load_cnt <= r_load_cnt + CNT_W'(1);
    end else begin
      r_load_cnt <= r_load_cnt;
    end
  end

  // Saturating count of completed stores.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_store_cnt <= '0;
    end else if (w_retire && w_store && (r_store_cnt != '1)) begin
      r_store_cnt <= r_store_cnt + CNT_W'(1);
    end else begin
      r_store_cnt <= r_store_cnt;
    end
  end

  assign LoadCount  = r_load_cnt;
  assign StoreCount = r_store_cnt;
`else
  // CNT_W only sizes the performance counters; nothing to build without them.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_data_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_data_mem_stage
// Directed scenarios with literal expectations, then randomized instructions.
// A cycle-level model (elapsed cycles of the current instruction, a word array
// and a couple of registers) predicts every output at each falling edge.
// -----------------------------------------------------------------------------
module tb_data_mem_stage;

  localparam int ADDR_W = 8;
  localparam int WC     = 2;
  localparam int CNTW   = 2;
  localparam int NWORDS = 1 << ADDR_W;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] ALU_result;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemtoReg;
  logic [31:0] DataToWd;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AddrErr;
`ifdef DMEM_PERF_CNT_EN
  logic [CNTW-1:0] LoadCount;
  logic [CNTW-1:0] StoreCount;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  data_mem_stage #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WC),
    .CNT_W       (CNTW)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ALU_result (ALU_result),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .DataToWd   (DataToWd),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .AddrErr    (AddrErr)
`ifdef DMEM_PERF_CNT_EN
    ,
    .LoadCount  (LoadCount),
    .StoreCount (StoreCount)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]     m_mem [NWORDS];
  int              m_age;   // cycles the current instruction has been presented
  logic [31:0]     m_rd;
  logic            m_err;
  int              m_lc;
  int              m_sc;
  localparam int   CMAX = (1 << CNTW) - 1;

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % NWORDS);
  endfunction

  // Model update: an aligned access retires after WC+2 presented cycles.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_age <= 0;
      m_rd  <= 32'h0;
      m_err <= 1'b0;
      m_lc  <= 0;
      m_sc  <= 0;
    end else if (!(MemWrite || MemtoReg)) begin
      m_age <= 0;
    end else if (ALU_result[1:0] != 2'b00) begin
      m_err <= 1'b1;
      m_age <= 0;
    end else if (m_age < WC + 1) begin
      m_age <= m_age + 1;
    end else begin
      m_age <= 0;
      if (MemWrite) begin
        m_mem[word_of(ALU_result)] <= WriteData;
        if (m_sc < CMAX) m_sc <= m_sc + 1;
      end else begin
        m_rd <= m_mem[word_of(ALU_result)];
        if (m_lc < CMAX) m_lc <= m_lc + 1;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge Clock) begin : cmp_blk
    logic        e_stall;
    logic [31:0] e_dtw;
    logic        req;
    logic        mis;
    logic        ld;
    req = MemWrite | MemtoReg;
    mis = req && (ALU_result[1:0] != 2'b00);
    ld  = MemtoReg && !MemWrite;
    e_stall = 1'b0;
    e_dtw   = ALU_result;
    if (Reset) begin
      if (mis) begin
        e_dtw = ld ? 32'h0 : ALU_result;
      end else if (req && m_age < WC + 1) begin
        e_stall = 1'b1;
      end else if (req && ld) begin
        e_dtw = m_mem[word_of(ALU_result)];
      end
    end
    chk("Stall",    {31'd0, Stall}, {31'd0, e_stall});
    chk("DataToWd", DataToWd, e_dtw);
    chk("ReadData", ReadData, Reset ? m_rd : 32'h0);
    chk("AddrErr",  {31'd0, AddrErr}, {31'd0, (Reset ? m_err : 1'b0)});
`ifdef DMEM_PERF_CNT_EN
    chk("LoadCount",  32'(LoadCount),  Reset ? 32'(m_lc) : 32'h0);
    chk("StoreCount", 32'(StoreCount), Reset ? 32'(m_sc) : 32'h0);
`endif
  end

  // ---------------- driver ----------------
  // Present one instruction at posedge+1 and hold it until Stall drops
  // (bounded); returns stalled-cycle count and DataToWd of the final cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                       input logic mw, input logic mr,
                       output int stalls, output logic [31:0] dtw);
    bit done;
    ALU_result = a;
    WriteData  = wd;
    MemWrite   = mw;
    MemtoReg   = mr;
    stalls = 0;
    dtw    = 32'h0;
    done   = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge Clock);
      if (Stall === 1'b1) stalls++;
      else begin
        dtw  = DataToWd;
        done = 1'b1;
      end
    end
    if (!done) chk("stall_bound", 32'(stalls), 32'd15);
    @(posedge Clock);
    #1;
  endtask

  task automatic nop();
    ALU_result = $urandom();
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int          st;
    logic [31:0] d;
    logic [31:0] a;
    int          k;

    Reset = 1'b1;
    ALU_result = 32'h0000_0055;
    WriteData  = 32'h0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b1;
    #1 Reset = 1'b0;
    #1;
    // Reset state, with a load request already presented.
    chk("rst_stall",    {31'd0, Stall}, 32'd0);
    chk("rst_dtw",      DataToWd, 32'h0000_0055);
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_addrerr",  {31'd0, AddrErr}, 32'd0);
    @(posedge Clock); #1;
    MemtoReg = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;

    // Preload every word with zero.
    for (int i = 0; i < NWORDS; i++) issue(32'(i) << 2, 32'h0, 1'b1, 1'b0, st, d);

    // ALU pass-through.
    ALU_result = 32'h1234_5678; MemWrite = 1'b0; MemtoReg = 1'b0;
    #1;
    chk("pass_dtw",   DataToWd, 32'h1234_5678);
    chk("pass_stall", {31'd0, Stall}, 32'd0);
    @(posedge Clock); #1;

    // Store / load round trip.
    issue(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, st, d);
    chk("st_stall_cycles", 32'(st), 32'd3);
    issue(32'h0000_0010, 32'h0, 1'b0, 1'b1, st, d);
    chk("ld_stall_cycles", 32'(st), 32'd3);
    chk("ld_dtw", d, 32'hDEAD_BEEF);
    chk("ld_readdata", ReadData, 32'hDEAD_BEEF);

    // Misaligned load, then an aligned one.
    issue(32'h0000_0013, 32'h0, 1'b0, 1'b1, st, d);
    chk("mis_stall_cycles", 32'(st), 32'd0);
    chk("mis_dtw", d, 32'h0);
    chk("mis_addrerr", {31'd0, AddrErr}, 32'd1);
    issue(32'h0000_0010, 32'h0, 1'b0, 1'b1, st, d);
    chk("after_mis_dtw", d, 32'hDEAD_BEEF);
    chk("sticky_addrerr", {31'd0, AddrErr}, 32'd1);

    // Aliasing: 0x404 and 0x004 hit the same word.
    issue(32'h0000_0404, 32'h0000_0001, 1'b1, 1'b0, st, d);
    issue(32'h0000_0004, 32'h0, 1'b0, 1'b1, st, d);
    chk("alias_dtw", d, 32'h0000_0001);

    // Both request bits: a store that returns the ALU value.
    issue(32'h0000_0030, 32'h0BAD_F00D, 1'b1, 1'b1, st, d);
    chk("both_dtw", d, 32'h0000_0030);

    // Reset in the second WAIT cycle of a store drops the store.
    ALU_result = 32'h0000_0020; WriteData = 32'hA5A5_A5A5;
    MemWrite = 1'b1; MemtoReg = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    #1;
    chk("midrst_stall",    {31'd0, Stall}, 32'd0);
    chk("midrst_readdata", ReadData, 32'h0);
    chk("midrst_addrerr",  {31'd0, AddrErr}, 32'd0);
    MemWrite = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
`ifdef DMEM_PERF_CNT_EN
    issue(32'h0000_0041, 32'h0, 1'b0, 1'b1, st, d);
    chk("perf_mis_load", 32'(LoadCount), 32'd0);
    for (int i = 0; i < 5; i++) issue(32'h0000_0040, 32'h0, 1'b1, 1'b0, st, d);
    chk("perf_store_sat", 32'(StoreCount), 32'd3);
`endif
    issue(32'h0000_0020, 32'h0, 1'b0, 1'b1, st, d);
    chk("midrst_ld_dtw", d, 32'h0);
    chk("midrst_ld_rd",  ReadData, 32'h0);

    // Randomized instruction stream on a small aliased address window.
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 9));
      a = $urandom();
      a[9:6] = 4'h0;
      a[1:0] = 2'b00;
      if (k == 9) a[1:0] = 2'($urandom_range(1, 3));
      case (k)
        0, 1, 2, 3: issue(a, $urandom(), 1'b0, 1'b0, st, d);
        4, 5:       issue(a, $urandom(), 1'b1, 1'b0, st, d);
        6, 7:       issue(a, $urandom(), 1'b0, 1'b1, st, d);
        8:          issue(a, $urandom(), 1'b1, 1'b1, st, d);
        default:    issue(a, $urandom(), 1'($urandom_range(0, 1)), 1'b1, st, d);
      endcase
    end
    nop();
    nop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
